// File: rtl/ekf_stage_seq.sv
// Stage sequencer for the EKF nonlinear unit: grants one predict/newlm/update
// request at a time, starts the unit, waits for completion and buffers the result.
//
// state | meaning
// IDLE  | grant lowest requested stage, screen landmark index / capacity
// ISSUE | one-cycle init pulse to the nonlinear unit, clear wait counter
// WAIT  | count cycles for the matching done strobe, timeout at TMO
// OUT   | hold captured result until downstream takes it
module ekf_stage_seq #(
  parameter int DW      = 32,
  parameter int ROW_LEN = 10,
  parameter int NRES    = 6,
  parameter int TMO     = 255,
  parameter int MAX_LM  = 2**ROW_LEN-1
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic [2:0]           stage_val,
  output logic [2:0]           stage_rdy,
  input  logic [ROW_LEN-1:0]   l_k,
  output logic                 init_predict,
  output logic                 init_newlm,
  output logic                 init_update,
  input  logic                 done_predict,
  input  logic                 done_newlm,
  input  logic                 done_update,
  input  logic [NRES*DW-1:0]   result_in,
  output logic                 res_val,
  input  logic                 res_rdy,
  output logic [NRES*DW-1:0]   res_data,
  output logic [2:0]           res_stage,
  output logic [ROW_LEN-1:0]   res_lk,
  output logic [ROW_LEN-1:0]   landmark_num,
  output logic                 err_timeout,
  output logic                 err_lk,
  output logic                 err_full
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               r_state;
  logic [2:0]           r_stage;
  logic [ROW_LEN-1:0]   r_lk;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_init;
  logic [ROW_LEN-1:0]   r_landmark_num;
  logic                 r_res_val;
  logic [NRES*DW-1:0]   r_res_data;
  logic [2:0]           r_res_stage;
  logic [ROW_LEN-1:0]   r_res_lk;
  logic                 r_err_timeout;
  logic                 r_err_lk;
  logic                 r_err_full;

  logic [2:0]           w_grant;
  logic [2:0]           w_done;
  logic                 w_done_match;
  logic                 w_lk_bad;
  logic                 w_full;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_tmo;

  // Fixed priority: predict over newlm over update.
  always_comb begin
    w_grant = 3'b000;
    if (r_state == S_IDLE) begin
      if (stage_val[0])      w_grant = 3'b001;
      else if (stage_val[1]) w_grant = 3'b010;
      else if (stage_val[2]) w_grant = 3'b100;
    end
  end

  assign w_done       = {done_update, done_newlm, done_predict};
  assign w_done_match = |(w_done & r_stage);
  assign w_lk_bad     = (l_k >= r_landmark_num);
  assign w_full       = (r_landmark_num == ROW_LEN'(MAX_LM));
  assign w_cnt_nxt    = r_cnt + CW'(1);
  assign w_tmo        = (w_cnt_nxt == CW'(TMO));

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state        <= S_IDLE;
      r_stage        <= 3'b000;
      r_lk           <= '0;
      r_cnt          <= '0;
      r_init         <= 3'b000;
      r_landmark_num <= '0;
      r_res_val      <= 1'b0;
      r_res_data     <= '0;
      r_res_stage    <= 3'b000;
      r_res_lk       <= '0;
      r_err_timeout  <= 1'b0;
      r_err_lk       <= 1'b0;
      r_err_full     <= 1'b0;
    end else begin
      r_init        <= 3'b000;
      r_err_timeout <= 1'b0;
      r_err_lk      <= 1'b0;
      r_err_full    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_grant) begin
            r_stage <= w_grant;
            r_lk    <= l_k;
            // Rejected requests are consumed without touching the unit.
            if (w_grant[2] && w_lk_bad) begin
              r_err_lk <= 1'b1;
            end else if (w_grant[1] && w_full) begin
              r_err_full <= 1'b1;
            end else begin
              r_init  <= w_grant;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done landing on the last allowed cycle still counts.
          if (w_done_match) begin
            r_res_data  <= result_in;
            r_res_stage <= r_stage;
            r_res_lk    <= r_lk;
            r_res_val   <= 1'b1;
            if (r_stage[1]) r_landmark_num <= r_landmark_num + ROW_LEN'(1);
            r_state     <= S_OUT;
          end else if (w_tmo) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_OUT: begin
          if (res_rdy) begin
            r_res_val <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stage_rdy    = w_grant;
  assign init_predict = r_init[0];
  assign init_newlm   = r_init[1];
  assign init_update  = r_init[2];
  assign res_val      = r_res_val;
  assign res_data     = r_res_data;
  assign res_stage    = r_res_stage;
  assign res_lk       = r_res_lk;
  assign landmark_num = r_landmark_num;
  assign err_timeout  = r_err_timeout;
  assign err_lk       = r_err_lk;
  assign err_full     = r_err_full;

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Scoreboard bench for ekf_stage_seq: the driver queues expected init pulses,
// error pulses and results; a negedge monitor pops and compares them.
module tb_ekf_stage_seq;

  localparam int DW      = 32;
  localparam int ROW_LEN = 4;
  localparam int NRES    = 6;
  localparam int TMO     = 8;
  localparam int MAX_LM  = 5;

  logic               clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic [2:0]         stage_val = 3'b000;
  logic [2:0]         stage_rdy;
  logic [ROW_LEN-1:0] l_k = '0;
  logic               init_predict, init_newlm, init_update;
  logic               done_predict = 1'b0, done_newlm = 1'b0, done_update = 1'b0;
  logic [NRES*DW-1:0] result_in = '0;
  logic               res_val;
  logic               res_rdy = 1'b1;
  logic [NRES*DW-1:0] res_data;
  logic [2:0]         res_stage;
  logic [ROW_LEN-1:0] res_lk;
  logic [ROW_LEN-1:0] landmark_num;
  logic               err_timeout, err_lk, err_full;

  typedef struct {
    logic [2:0]         stage;
    logic [ROW_LEN-1:0] lk;
    logic [NRES*DW-1:0] data;
  } res_t;

  res_t       res_q[$];
  logic [2:0] init_q[$];
  logic [2:0] err_q[$];
  res_t       mon_r;
  logic [2:0] mon_c;

  int checks = 0;
  int failures = 0;

  ekf_stage_seq #(
    .DW(DW), .ROW_LEN(ROW_LEN), .NRES(NRES), .TMO(TMO), .MAX_LM(MAX_LM)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .stage_val(stage_val), .stage_rdy(stage_rdy), .l_k(l_k),
    .init_predict(init_predict), .init_newlm(init_newlm), .init_update(init_update),
    .done_predict(done_predict), .done_newlm(done_newlm), .done_update(done_update),
    .result_in(result_in),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
    .res_stage(res_stage), .res_lk(res_lk), .landmark_num(landmark_num),
    .err_timeout(err_timeout), .err_lk(err_lk), .err_full(err_full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] words(input logic [31:0] base);
    logic [191:0] d;
    for (int i = 0; i < NRES; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  always @(negedge clk) begin
    if (!sys_rst) begin
      if (res_val && res_rdy) begin
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got stage %b expected none", res_stage);
        end else begin
          mon_r = res_q.pop_front();
          check("res_stage", 192'(res_stage), 192'(mon_r.stage));
          check("res_lk", 192'(res_lk), 192'(mon_r.lk));
          check("res_data", res_data, mon_r.data);
        end
      end
      if (err_timeout || err_lk || err_full) begin
        if (err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_err: got %b expected none", {err_timeout, err_lk, err_full});
        end else begin
          mon_c = err_q.pop_front();
          check("err_code", 192'({err_timeout, err_lk, err_full}), 192'(mon_c));
        end
      end
      if (init_predict || init_newlm || init_update) begin
        if (init_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_init: got %b expected none", {init_update, init_newlm, init_predict});
        end else begin
          mon_c = init_q.pop_front();
          check("init_code", 192'({init_update, init_newlm, init_predict}), 192'(mon_c));
        end
      end
    end
  end

  // Presents a request for one cycle; leaves the caller in the cycle after transfer.
  task automatic issue(input logic [2:0] val, input logic [2:0] exp_g, input logic [3:0] lk,
                       input logic [2:0] exp_init, input logic [2:0] exp_err, input logic [2:0] rest);
    stage_val = val;
    l_k = lk;
    if (exp_init != 3'b000) init_q.push_back(exp_init);
    if (exp_err != 3'b000) err_q.push_back(exp_err);
    @(negedge clk);
    check("grant", 192'(stage_rdy), 192'(exp_g));
    @(posedge clk); #1;
    stage_val = rest;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!res_val) break;
      @(posedge clk); #1;
    end
    check("idle_reached", 192'(res_val), 192'(0));
  endtask

  // Called in the init cycle; done arrives dly cycles after the earliest slot.
  task automatic complete(input logic [2:0] sel, input int dly, input logic [31:0] base,
                          input logic [3:0] lk);
    res_t r;
    r.stage = sel; r.lk = lk; r.data = words(base);
    res_q.push_back(r);
    @(negedge clk);
    check("init_latency", 192'({init_update, init_newlm, init_predict}), 192'(sel));
    check("rdy_busy", 192'(stage_rdy), 192'(0));
    repeat (dly + 1) @(posedge clk);
    #1;
    result_in = words(base);
    {done_update, done_newlm, done_predict} = sel;
    @(posedge clk); #1;
    {done_update, done_newlm, done_predict} = 3'b000;
    @(negedge clk);
    check("res_latency", 192'(res_val), 192'(1));
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_val", 192'(res_val), 192'(0));
    check("rst_landmark", 192'(landmark_num), 192'(0));
    check("rst_init", 192'({init_update, init_newlm, init_predict}), 192'(0));
    check("rst_err", 192'({err_timeout, err_lk, err_full}), 192'(0));
    check("rst_res_data", res_data, 192'(0));
    check("rst_res_stage_lk", 192'({res_stage, res_lk}), 192'(0));
    check("rst_stage_rdy", 192'(stage_rdy), 192'(0));
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // Predict, done 5 cycles after init.
    issue(3'b001, 3'b001, 4'd0, 3'b001, 3'b000, 3'b000);
    complete(3'b001, 4, 32'd1, 4'd0);
    check("predict_landmark", 192'(landmark_num), 192'(0));

    // Three new landmarks, then update boundary.
    for (int n = 0; n < 3; n++) begin
      issue(3'b010, 3'b010, 4'd0, 3'b010, 3'b000, 3'b000);
      complete(3'b010, n, 32'h10 + 32'(n * 16), 4'd0);
    end
    check("newlm_count3", 192'(landmark_num), 192'(3));
    issue(3'b100, 3'b100, 4'd2, 3'b100, 3'b000, 3'b000);
    complete(3'b100, 1, 32'h40, 4'd2);
    issue(3'b100, 3'b100, 4'd3, 3'b000, 3'b010, 3'b000);
    @(negedge clk);
    check("lk_err_pulse", 192'(err_lk), 192'(1));
    check("lk_err_no_init", 192'({init_update, init_newlm, init_predict}), 192'(0));
    @(posedge clk); #1;

    // newlm and update requested together; update waits for the handshake.
    issue(3'b110, 3'b010, 4'd1, 3'b010, 3'b000, 3'b100);
    complete(3'b010, 2, 32'h50, 4'd1);
    check("newlm_count4", 192'(landmark_num), 192'(4));
    issue(3'b100, 3'b100, 4'd1, 3'b100, 3'b000, 3'b000);
    complete(3'b100, 0, 32'h60, 4'd1);

    // Timeout with a foreign done strobe in between.
    issue(3'b001, 3'b001, 4'd5, 3'b001, 3'b100, 3'b000);
    @(posedge clk); #1;
    done_newlm = 1'b1;
    result_in = words(32'hdead0000);
    @(posedge clk); #1;
    done_newlm = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("tmo_not_early", 192'(err_timeout), 192'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_pulse", 192'(err_timeout), 192'(1));
    check("tmo_no_res", 192'(res_val), 192'(0));
    check("tmo_landmark", 192'(landmark_num), 192'(4));
    @(posedge clk); #1;

    // Done on the last allowed cycle is captured.
    issue(3'b001, 3'b001, 4'd6, 3'b001, 3'b000, 3'b000);
    complete(3'b001, TMO - 1, 32'h70, 4'd6);

    // Back-pressure with a pending predict request.
    res_rdy = 1'b0;
    begin
      res_t r;
      r.stage = 3'b001; r.lk = 4'd7; r.data = words(32'h80);
      res_q.push_back(r);
    end
    issue(3'b001, 3'b001, 4'd7, 3'b001, 3'b000, 3'b001);
    @(posedge clk); #1;
    result_in = words(32'h80);
    done_predict = 1'b1;
    @(posedge clk); #1;
    done_predict = 1'b0;
    result_in = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_res_val", 192'(res_val), 192'(1));
      check("hold_res_data", res_data, words(32'h80));
      check("hold_stage_rdy", 192'(stage_rdy), 192'(0));
      @(posedge clk); #1;
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("grant_after_hold", 192'(stage_rdy), 192'(3'b001));
    stage_val = 3'b000;
    @(posedge clk); #1;

    // Fill to capacity, then overflow attempt.
    issue(3'b010, 3'b010, 4'd0, 3'b010, 3'b000, 3'b000);
    complete(3'b010, 0, 32'h90, 4'd0);
    check("landmark_full", 192'(landmark_num), 192'(MAX_LM));
    issue(3'b010, 3'b010, 4'd0, 3'b000, 3'b001, 3'b000);
    @(negedge clk);
    check("full_err_pulse", 192'(err_full), 192'(1));
    check("full_no_init", 192'({init_update, init_newlm, init_predict}), 192'(0));
    check("full_landmark", 192'(landmark_num), 192'(MAX_LM));
    @(posedge clk); #1;

    // Reset while waiting, then a stale done.
    issue(3'b100, 3'b100, 4'd2, 3'b100, 3'b000, 3'b000);
    @(posedge clk); #1;
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    done_update = 1'b1;
    result_in = words(32'ha0);
    @(posedge clk); #1;
    done_update = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_res_val", 192'(res_val), 192'(0));
      check("postrst_landmark", 192'(landmark_num), 192'(0));
      check("postrst_res", 192'({res_data, res_stage, res_lk}), 192'(0));
      check("postrst_pulses", 192'({err_timeout, err_lk, err_full, init_update, init_newlm, init_predict}), 192'(0));
      @(posedge clk); #1;
    end

    check("res_q_empty", 192'(res_q.size()), 192'(0));
    check("init_q_empty", 192'(init_q.size()), 192'(0));
    check("err_q_empty", 192'(err_q.size()), 192'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ekf_stage_seq.md
EKF_STAGE_SEQ -- requirements
Module: ekf_stage_seq

Interface
REQ-001 Parameter DW, default 32, data width of one nonlinear result word.
REQ-002 Parameter ROW_LEN, default 10, width of landmark index and landmark count.
REQ-003 Parameter NRES, default 6, number of result words per stage.
REQ-004 Parameter TMO, default 255, maximum wait cycles for done before timeout; TMO ≥ 2.
REQ-005 Parameter MAX_LM, default 2**ROW_LEN-1, landmark capacity.
REQ-006 Clocking: one clock, clk; reset sys_rst is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 sys_rst  in  1  synchronous active-high reset.
REQ-009 stage_val  in  3  stage request, bit0 predict, bit1 newlm, bit2 update.
REQ-010 stage_rdy  out  3  per-stage grant; transfer when stage_val[i] && stage_rdy[i].
REQ-011 l_k  in  ROW_LEN  landmark index, sampled on transfer.
REQ-012 init_predict, init_newlm, init_update  out  1 each  start pulses to nonlinear unit.
REQ-013 done_predict, done_newlm, done_update  in  1 each  completion strobes from nonlinear unit.
REQ-014 result_in  in  NRES*DW  result words, word i at bits [i*DW +: DW], valid with the done strobe.
REQ-015 res_val  out  1  result buffer valid.
REQ-016 res_rdy  in  1  downstream accepts result.
REQ-017 res_data  out  NRES*DW  captured result words.
REQ-018 res_stage  out  3  one-hot stage of captured result.
REQ-019 res_lk  out  ROW_LEN  l_k latched for this result.
REQ-020 landmark_num  out  ROW_LEN  current landmark count.
REQ-021 err_timeout, err_lk, err_full  out  1 each  single-cycle error pulses.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, OUT; one stage in flight at a time.
REQ-023 IDLE: stage_rdy = lowest-set-bit of stage_val (predict > newlm > update priority); stage_rdy = 0 in all other states.
REQ-024 On transfer: latch stage one-hot and l_k; go ISSUE unless REQ-025/026 applies.
REQ-025 Update transfer with l_k ≥ landmark_num: err_lk pulse next cycle, no init, stay IDLE.
REQ-026 Newlm transfer with landmark_num == MAX_LM: err_full pulse next cycle, no init, stay IDLE.
REQ-027 ISSUE: exactly one of init_* high for one cycle, matching latched stage; clear wait counter; go WAIT.
REQ-028 WAIT: counter increments each cycle; only the done_* matching latched stage is honoured; others ignored.
REQ-029 Matching done: capture result_in into res_data, set res_stage, res_lk; newlm increments landmark_num by 1 in same cycle; go OUT.
REQ-030 Counter reaching TMO without matching done: err_timeout pulse, no capture, go IDLE; done on the same cycle as the TMO limit wins over timeout.
REQ-031 OUT: res_val = 1, res_data/res_stage/res_lk stable until res_val && res_rdy; then IDLE with res_val = 0.
REQ-032 Latency: transfer at cycle T → init at T+1 → earliest done at T+2 → res_val at T+3; back-to-back request granted in the cycle after the result handshake.
REQ-033 landmark_num changes only on newlm completion or reset; never wraps.

Reset
REQ-034 sys_rst sampled high: state IDLE, landmark_num = 0, all init_*, err_*, res_val = 0, res_data = 0, res_stage = 0, res_lk = 0, counter = 0.
REQ-035 Reset mid-operation abandons the stage; done strobes arriving after reset in IDLE are ignored with no capture.

Verification
REQ-036 Predict: stage_val=001, done_predict 5 cycles after init with result_in words 1..6 -> init_predict one pulse at T+1, res_val with res_stage=001, words 1..6, landmark_num stays 0.
REQ-037 Newlm ×3 then update l_k=2 -> landmark_num=3, update proceeds; update l_k=3 -> err_lk pulse, no init_update.
REQ-038 stage_val=110 in IDLE -> stage_rdy=010, init_newlm only; update granted after result handshake.
REQ-039 TMO=8, no done -> err_timeout after 8 WAIT cycles, IDLE, res_val stays 0; done on the 8th cycle -> capture, no err_timeout.
REQ-040 res_rdy held low 10 cycles while stage_val=001 -> res_val and res_data stable, stage_rdy=000 throughout.
REQ-041 sys_rst asserted in WAIT, then done_update -> all outputs reset values, no res_val, landmark_num=0.
